// File: rtl/mmio_uart_arbiter_if.sv
// Request/response link used between MMIO masters, the arbiter and the UART slave.
// "master" drives a request and waits for done; "slave" answers it.
interface mmio_uart_arbiter_if;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] rdata;

    modport master (output read, write, addr, wdata, input done, rdata);
    modport slave  (input read, write, addr, wdata, output done, rdata);
endinterface

// File: rtl/mmio_uart_arbiter.sv
// Two-master round-robin arbiter for the UART MMIO window with a per-transaction
// grant lock, a one-cycle GAP between transactions and a completion watchdog.
module mmio_uart_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    mmio_uart_arbiter_if.slave   m0,
    mmio_uart_arbiter_if.slave   m1,
    mmio_uart_arbiter_if.master  s,
    output logic                 m0_err,
    output logic                 m1_err,
    output logic                 grant,
    output logic                 busy
);

    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_BUSY  = 2'd1;
    localparam logic [1:0]       ST_GAP   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_r;
    logic             last_r;
    logic             grant_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic             m0_done_r;
    logic             m1_done_r;
    logic             m0_err_r;
    logic             m1_err_r;
    logic [31:0]      m0_rdata_r;
    logic [31:0]      m1_rdata_r;

    logic             req0_s;
    logic             req1_s;
    logic             greq_s;
    logic             pick_s;
    logic             tmo_s;
    logic             cmpl_s;
    logic             fwd_read_s;
    logic             fwd_write_s;
    logic [31:0]      fwd_addr_s;
    logic [31:0]      fwd_wdata_s;

    assign req0_s = m0.read | m0.write;
    assign req1_s = m1.read | m1.write;
    assign tmo_s  = (cnt_r == CNT_LAST);
    // A slave done in the watchdog's last cycle still wins and completes without error.
    assign cmpl_s = (state_r == ST_BUSY) && (s.done || tmo_s);

    // Round-robin pick: on a tie the master that did not own the previous transaction wins.
    always_comb begin
        pick_s = 1'b0;
        if (req0_s && req1_s) begin
            pick_s = ~last_r;
        end else if (req1_s) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Request line of the current owner, watched for an abort while BUSY.
    always_comb begin
        greq_s = 1'b0;
        if (grant_r) begin
            greq_s = req1_s;
        end else begin
            greq_s = req0_s;
        end
    end

    // Forwarding mux: only the owning master reaches the slave, and only in BUSY.
    always_comb begin
        fwd_read_s  = 1'b0;
        fwd_write_s = 1'b0;
        fwd_addr_s  = 32'd0;
        fwd_wdata_s = 32'd0;
        if (state_r == ST_BUSY) begin
            if (grant_r) begin
                fwd_read_s  = m1.read;
                fwd_write_s = m1.write;
                fwd_addr_s  = m1.addr;
                fwd_wdata_s = m1.wdata;
            end else begin
                fwd_read_s  = m0.read;
                fwd_write_s = m0.write;
                fwd_addr_s  = m0.addr;
                fwd_wdata_s = m0.wdata;
            end
        end else begin
            fwd_read_s  = 1'b0;
            fwd_write_s = 1'b0;
            fwd_addr_s  = 32'd0;
            fwd_wdata_s = 32'd0;
        end
    end

    // Transaction sequencer: ownership, round-robin history and watchdog count.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            last_r  <= 1'b1;
            grant_r <= 1'b0;
            busy_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (req0_s || req1_s) begin
                        grant_r <= pick_s;
                        state_r <= ST_BUSY;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (cmpl_s) begin
                        state_r <= ST_GAP;
                        busy_r  <= 1'b1;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end else if (!greq_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= ST_BUSY;
                        busy_r  <= 1'b1;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    last_r  <= grant_r;
                    cnt_r   <= CNT_ZERO;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Completion pulses: one cycle wide, data and error cleared again right after.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            m0_done_r  <= 1'b0;
            m1_done_r  <= 1'b0;
            m0_err_r   <= 1'b0;
            m1_err_r   <= 1'b0;
            m0_rdata_r <= 32'd0;
            m1_rdata_r <= 32'd0;
        end else begin
            m0_done_r <= cmpl_s & ~grant_r;
            m1_done_r <= cmpl_s & grant_r;
            m0_err_r  <= cmpl_s & ~grant_r & ~s.done;
            m1_err_r  <= cmpl_s & grant_r & ~s.done;
            if (cmpl_s && s.done && !grant_r) begin
                m0_rdata_r <= s.rdata;
            end else begin
                m0_rdata_r <= 32'd0;
            end
            if (cmpl_s && s.done && grant_r) begin
                m1_rdata_r <= s.rdata;
            end else begin
                m1_rdata_r <= 32'd0;
            end
        end
    end

    assign s.read   = fwd_read_s;
    assign s.write  = fwd_write_s;
    assign s.addr   = fwd_addr_s;
    assign s.wdata  = fwd_wdata_s;
    assign m0.done  = m0_done_r;
    assign m0.rdata = m0_rdata_r;
    assign m1.done  = m1_done_r;
    assign m1.rdata = m1_rdata_r;
    assign m0_err   = m0_err_r;
    assign m1_err   = m1_err_r;
    assign grant    = grant_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_mmio_uart_arbiter.sv
// Bench for mmio_uart_arbiter: directed latency/arbitration scenarios plus random
// traffic from both masters against a UART slave model and a per-master scoreboard.
module tb_mmio_uart_arbiter;

    logic sys_clk = 1'b0;
    logic rst;
    logic m0_err, m1_err, grant, busy;

    mmio_uart_arbiter_if m0_bus ();
    mmio_uart_arbiter_if m1_bus ();
    mmio_uart_arbiter_if s_bus ();

    mmio_uart_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .m0_err  (m0_err),
        .m1_err  (m1_err),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          fwd_cnt;
    int          slave_lat;
    int          slave_lat_ovr = 0;
    bit          slave_fixed_en = 1'b0;
    logic [31:0] slave_fixed = 32'd0;
    logic        lf_read = 1'b0;
    logic        lf_write = 1'b0;
    logic [31:0] lf_addr = 32'd0;
    logic [31:0] lf_wdata = 32'd0;
    int          order[$];

    function automatic bit in_window(input logic [31:0] a);
        return a[31:5] == 27'h7FF_F809;
    endfunction

    function automatic logic [31:0] resp_of(input logic [31:0] a, input logic [31:0] w);
        return (a * 32'h9E37_79B1) ^ w ^ 32'h0000_0100;
    endfunction

    // UART slave: window addresses answer after addr[3:2]+1 cycles, others never.
    initial begin
        s_bus.done  = 1'b0;
        s_bus.rdata = 32'd0;
        fwd_cnt     = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (s_bus.read || s_bus.write) begin
                fwd_cnt++;
                lf_read  = s_bus.read;
                lf_write = s_bus.write;
                lf_addr  = s_bus.addr;
                lf_wdata = s_bus.wdata;
                if (slave_lat_ovr != 0) slave_lat = slave_lat_ovr;
                else if (in_window(s_bus.addr)) slave_lat = int'(s_bus.addr[3:2]) + 1;
                else slave_lat = 1000000;
                if (fwd_cnt == slave_lat + 1) begin
                    s_bus.done  = 1'b1;
                    s_bus.rdata = slave_fixed_en ? slave_fixed : resp_of(s_bus.addr, s_bus.wdata);
                end else begin
                    s_bus.done  = 1'b0;
                    s_bus.rdata = $urandom;
                end
            end else begin
                fwd_cnt     = 0;
                s_bus.done  = 1'b0;
                s_bus.rdata = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, required to end by 500000", $time);
        $fatal(1, "simulation time limit reached");
    end

    task automatic drive_req(input int id, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] w);
        if (id == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.addr = a; m0_bus.wdata = w;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.addr = a; m1_bus.wdata = w;
        end
    endtask

    function automatic logic get_done(input int id);
        if (id == 0) return m0_bus.done;
        else return m1_bus.done;
    endfunction

    function automatic logic [31:0] get_rdata(input int id);
        if (id == 0) return m0_bus.rdata;
        else return m1_bus.rdata;
    endfunction

    function automatic logic get_err(input int id);
        if (id == 0) return m0_err;
        else return m1_err;
    endfunction

    task automatic do_reset();
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
    endtask

    // One master issuing n transactions; each completion is scored against the model.
    task automatic master_run(input int id, input int n, input bit rnd);
        logic [31:0] a, w, exp_rd;
        logic        rd, wr, exp_err, got;
        int          waited;
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge sys_clk);
                    n_checks++;
                    if (get_done(id) !== 1'b0) begin
                        n_fail++;
                        $display("FAIL m%0d_spurious_done: got %b, expected 0", id, get_done(id));
                    end
                end
                rd = 1'($urandom_range(0, 1));
                wr = ~rd;
                if ($urandom_range(0, 7) == 0) a = 32'hFFFF_0200 | ($urandom & 32'h0000_01FF);
                else a = 32'hFFFF_0120 | ($urandom & 32'h0000_001F);
                w = $urandom;
            end else begin
                rd = 1'b1;
                wr = 1'b0;
                a  = (id == 0) ? 32'hFFFF_0120 : 32'hFFFF_0124;
                w  = 32'd0;
            end
            exp_err = ~in_window(a);
            exp_rd  = exp_err ? 32'd0 : resp_of(a, w);
            drive_req(id, rd, wr, a, w);
            waited = 0;
            got    = 1'b0;
            while (!got && waited < 400) begin
                @(negedge sys_clk);
                waited++;
                got = get_done(id);
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL m%0d_no_done: none after %0d cycles, expected within 400", id, waited);
                drive_req(id, 1'b0, 1'b0, 32'd0, 32'd0);
                continue;
            end
            order.push_back(id);
            n_checks++;
            if (get_err(id) !== exp_err) begin
                n_fail++;
                $display("FAIL m%0d_err addr %h: got %b, expected %b", id, a, get_err(id), exp_err);
            end
            n_checks++;
            if (get_rdata(id) !== exp_rd) begin
                n_fail++;
                $display("FAIL m%0d_rdata addr %h: got %h, expected %h", id, a, get_rdata(id), exp_rd);
            end
            n_checks++;
            if ({lf_read, lf_write, lf_addr, lf_wdata} !== {rd, wr, a, w}) begin
                n_fail++;
                $display("FAIL m%0d_forwarded: got r%b w%b %h %h, expected r%b w%b %h %h",
                         id, lf_read, lf_write, lf_addr, lf_wdata, rd, wr, a, w);
            end
            drive_req(id, 1'b0, 1'b0, 32'd0, 32'd0);
            @(negedge sys_clk);
            n_checks++;
            if ({get_done(id), get_err(id), get_rdata(id)} !== 34'd0) begin
                n_fail++;
                $display("FAIL m%0d_pulse_clear: got done %b err %b rdata %h, expected all 0",
                         id, get_done(id), get_err(id), get_rdata(id));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_req(0, 1'b1, 1'b0, 32'hFFFF_0120, 32'd0);
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if ({m0_bus.done, m0_err, m1_bus.done, m1_err, s_bus.read, s_bus.write, grant, busy} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 00000000",
                     {m0_bus.done, m0_err, m1_bus.done, m1_err, s_bus.read, s_bus.write, grant, busy});
        end
        n_checks++;
        if ({m0_bus.rdata, m1_bus.rdata, s_bus.addr, s_bus.wdata} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h, expected all 0",
                     m0_bus.rdata, m1_bus.rdata, s_bus.addr, s_bus.wdata);
        end
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_single_read();
        do_reset();
        slave_fixed_en = 1'b1;
        slave_fixed    = 32'h0000_0001;
        drive_req(0, 1'b1, 1'b0, 32'hFFFF_0120, 32'd0);
        @(negedge sys_clk);
        n_checks++;
        if ({s_bus.read, s_bus.addr, grant, busy} !== {1'b1, 32'hFFFF_0120, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_forward: got rd %b addr %h grant %b busy %b, expected 1 ffff0120 0 1",
                     s_bus.read, s_bus.addr, grant, busy);
        end
        @(negedge sys_clk);
        n_checks++;
        if (m0_bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_done: got %b at cycle 2, expected 0", m0_bus.done);
        end
        @(negedge sys_clk);
        n_checks++;
        if ({m0_bus.done, m0_err, m0_bus.rdata} !== {1'b1, 1'b0, 32'h0000_0001}) begin
            n_fail++;
            $display("FAIL single_done_c3: got done %b err %b rdata %h, expected 1 0 00000001",
                     m0_bus.done, m0_err, m0_bus.rdata);
        end
        n_checks++;
        if ({m1_bus.done, m1_err, m1_bus.rdata} !== 34'd0) begin
            n_fail++;
            $display("FAIL single_m1_quiet: got done %b err %b rdata %h, expected all 0",
                     m1_bus.done, m1_err, m1_bus.rdata);
        end
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge sys_clk);
        n_checks++;
        if ({m0_bus.done, m0_bus.rdata, busy} !== 34'd0) begin
            n_fail++;
            $display("FAIL single_after: got done %b rdata %h busy %b, expected all 0",
                     m0_bus.done, m0_bus.rdata, busy);
        end
        slave_fixed_en = 1'b0;
    endtask

    task automatic test_tie();
        do_reset();
        drive_req(0, 1'b0, 1'b1, 32'hFFFF_0134, 32'h0000_0041);
        drive_req(1, 1'b1, 1'b0, 32'hFFFF_0128, 32'd0);
        @(negedge sys_clk);
        n_checks++;
        if ({s_bus.write, s_bus.read, s_bus.addr, s_bus.wdata, grant} !==
            {1'b1, 1'b0, 32'hFFFF_0134, 32'h0000_0041, 1'b0}) begin
            n_fail++;
            $display("FAIL tie_first: got w%b r%b %h %h grant %b, expected w1 r0 ffff0134 00000041 grant 0",
                     s_bus.write, s_bus.read, s_bus.addr, s_bus.wdata, grant);
        end
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if ({m0_bus.done, m0_err, m0_bus.rdata, m1_bus.done} !==
            {1'b1, 1'b0, resp_of(32'hFFFF_0134, 32'h0000_0041), 1'b0}) begin
            n_fail++;
            $display("FAIL tie_m0_done_c4: got done %b err %b rdata %h m1done %b, expected 1 0 %h 0",
                     m0_bus.done, m0_err, m0_bus.rdata, m1_bus.done, resp_of(32'hFFFF_0134, 32'h0000_0041));
        end
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge sys_clk);
        n_checks++;
        if ({s_bus.read, s_bus.addr} !== 33'd0) begin
            n_fail++;
            $display("FAIL tie_idle_quiet: got rd %b addr %h, expected 0 00000000", s_bus.read, s_bus.addr);
        end
        @(negedge sys_clk);
        n_checks++;
        if ({s_bus.read, s_bus.addr, grant} !== {1'b1, 32'hFFFF_0128, 1'b1}) begin
            n_fail++;
            $display("FAIL tie_second: got rd %b addr %h grant %b, expected 1 ffff0128 1",
                     s_bus.read, s_bus.addr, grant);
        end
        repeat (4) @(negedge sys_clk);
        n_checks++;
        if ({m1_bus.done, m1_err, m1_bus.rdata} !== {1'b1, 1'b0, resp_of(32'hFFFF_0128, 32'd0)}) begin
            n_fail++;
            $display("FAIL tie_m1_done: got done %b err %b rdata %h, expected 1 0 %h",
                     m1_bus.done, m1_err, m1_bus.rdata, resp_of(32'hFFFF_0128, 32'd0));
        end
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_alternate();
        do_reset();
        order.delete();
        fork
            master_run(0, 3, 1'b0);
            master_run(1, 3, 1'b0);
        join
        n_checks++;
        if (order.size() != 6) begin
            n_fail++;
            $display("FAIL alt_count: got %0d completions, expected 6", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            n_checks++;
            if (order[i] != (i % 2)) begin
                n_fail++;
                $display("FAIL alt_grant_%0d: got master %0d, expected %0d", i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_timeout(input bit coincide);
        int waited;
        bit other;
        do_reset();
        slave_lat_ovr = coincide ? 63 : 0;
        drive_req(1, 1'b1, 1'b0, coincide ? 32'hFFFF_0124 : 32'hFFFF_0200, 32'd0);
        waited = 0;
        other  = 1'b0;
        while (!m1_bus.done && waited < 100) begin
            @(negedge sys_clk);
            waited++;
            other = other | m0_bus.done;
        end
        n_checks++;
        if (waited != 65 || other) begin
            n_fail++;
            $display("FAIL tmo%0d_latency: got done at cycle %0d (m0 pulse %b), expected cycle 65 (m0 pulse 0)",
                     coincide, waited, other);
        end
        n_checks++;
        if (coincide && {m1_err, m1_bus.rdata} !== {1'b0, resp_of(32'hFFFF_0124, 32'd0)}) begin
            n_fail++;
            $display("FAIL tmo1_normal: got err %b rdata %h, expected 0 %h",
                     m1_err, m1_bus.rdata, resp_of(32'hFFFF_0124, 32'd0));
        end else if (!coincide && {m1_err, m1_bus.rdata} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL tmo0_error: got err %b rdata %h, expected 1 00000000", m1_err, m1_bus.rdata);
        end
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        slave_lat_ovr = 0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset_mid();
        int waited;
        bit other;
        do_reset();
        drive_req(0, 1'b1, 1'b0, 32'hFFFF_0128, 32'd0);
        repeat (2) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if ({s_bus.read, busy, m0_bus.done, m1_bus.done, grant} !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_abort: got rd %b busy %b done %b/%b grant %b, expected all 0",
                     s_bus.read, busy, m0_bus.done, m1_bus.done, grant);
        end
        rst = 1'b0;
        drive_req(1, 1'b1, 1'b0, 32'hFFFF_0120, 32'd0);
        @(negedge sys_clk);
        n_checks++;
        if ({grant, s_bus.addr} !== {1'b0, 32'hFFFF_0128}) begin
            n_fail++;
            $display("FAIL rstmid_tie: got grant %b addr %h, expected 0 ffff0128", grant, s_bus.addr);
        end
        waited = 0;
        other  = 1'b0;
        while (!m0_bus.done && waited < 20) begin
            @(negedge sys_clk);
            waited++;
            other = other | m1_bus.done;
        end
        n_checks++;
        if (waited != 4 || other) begin
            n_fail++;
            $display("FAIL rstmid_done: got m0 done after %0d (m1 pulse %b), expected 4 (m1 pulse 0)",
                     waited, other);
        end
        do_reset();
    endtask

    task automatic test_abort();
        do_reset();
        drive_req(0, 1'b1, 1'b0, 32'hFFFF_0300, 32'd0);
        drive_req(1, 1'b1, 1'b0, 32'hFFFF_0120, 32'd0);
        @(negedge sys_clk);
        n_checks++;
        if ({grant, s_bus.read, s_bus.addr} !== {1'b0, 1'b1, 32'hFFFF_0300}) begin
            n_fail++;
            $display("FAIL abort_first: got grant %b rd %b addr %h, expected 0 1 ffff0300",
                     grant, s_bus.read, s_bus.addr);
        end
        @(negedge sys_clk);
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge sys_clk);
        n_checks++;
        if ({busy, s_bus.read, m0_bus.done, m0_err} !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy %b rd %b done %b err %b, expected all 0",
                     busy, s_bus.read, m0_bus.done, m0_err);
        end
        @(negedge sys_clk);
        n_checks++;
        if ({grant, s_bus.read, s_bus.addr} !== {1'b1, 1'b1, 32'hFFFF_0120}) begin
            n_fail++;
            $display("FAIL abort_next: got grant %b rd %b addr %h, expected 1 1 ffff0120",
                     grant, s_bus.read, s_bus.addr);
        end
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if ({m1_bus.done, m1_bus.rdata, m0_bus.done} !== {1'b1, resp_of(32'hFFFF_0120, 32'd0), 1'b0}) begin
            n_fail++;
            $display("FAIL abort_m1_done: got done %b rdata %h m0done %b, expected 1 %h 0",
                     m1_bus.done, m1_bus.rdata, m0_bus.done, resp_of(32'hFFFF_0120, 32'd0));
        end
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge sys_clk);
    endtask

    task automatic test_random();
        do_reset();
        order.delete();
        fork
            master_run(0, 30, 1'b1);
            master_run(1, 30, 1'b1);
        join
        n_checks++;
        if (order.size() != 60) begin
            n_fail++;
            $display("FAIL random_count: got %0d completions, expected 60", order.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        test_reset();
        test_single_read();
        test_tie();
        test_alternate();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
